// File: rtl/mdu_iter.sv
// Radix-2 iterative RV32M-style multiply/divide unit with valid/ready handshakes.
// Optional MDU_EARLY_OUT_EN skips iteration for trivial operands (same result, shorter latency).
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  state_e            w_next_state;
  op_e               r_op;
  op_e               w_op;
  logic              w_accept;

  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_div0;
  logic              r_ovf;
  logic              r_mzero;
  logic [XLEN-1:0]   r_a_raw;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fix_ph;
  logic [2*XLEN-1:0] r_fix;
  logic [XLEN-1:0]   r_result;

  logic              w_is_mul;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div0;
  logic              w_ovf;
  logic              w_mzero;
  logic              w_early;
  logic              w_last;

  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_rsh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_hi_n;
  logic [XLEN-1:0]   w_lo_n;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [2*XLEN-1:0] w_fix;
  logic [XLEN-1:0]   w_sel;

  // Operand decode at the accepting edge
  assign w_op     = op_e'(op);
  assign w_is_mul = ~op[2];
  assign w_sgn_a  = a[XLEN-1] & ((w_op == OP_MULH) | (w_op == OP_MULHSU) |
                                 (w_op == OP_DIV)  | (w_op == OP_REM));
  assign w_sgn_b  = b[XLEN-1] & ((w_op == OP_MULH) | (w_op == OP_DIV) | (w_op == OP_REM));
  assign w_mag_a  = w_sgn_a ? ('0 - a) : a;
  assign w_mag_b  = w_sgn_b ? ('0 - b) : b;
  assign w_div0   = (b == '0);
  assign w_ovf    = ((w_op == OP_DIV) | (w_op == OP_REM)) & (a == MIN_NEG) & (b == '1);
  assign w_mzero  = (a == '0) | (b == '0);

`ifdef MDU_EARLY_OUT_EN
  assign w_early  = w_is_mul ? w_mzero : (w_div0 | w_ovf);
`else
  assign w_early  = 1'b0;
`endif

  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_rsh  = {r_hi, r_lo[XLEN-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_opnd});
  assign w_diff = w_rsh[XLEN-1:0] - r_opnd;

  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (r_op[2] == 1'b0) begin
      w_hi_n = w_madd[XLEN:1];
      w_lo_n = {w_madd[0], r_lo[XLEN-1:1]};
    end else begin
      w_hi_n = w_ge ? w_diff : w_rsh[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end
  end

  // Sign correction and special-case overrides; these also cover the early-out path
  assign w_prod = {r_hi, r_lo};

  always_comb begin
    w_fix  = '0;
    w_quot = r_lo;
    w_rem  = r_hi;
    if (r_op[2] == 1'b0) begin
      if (!r_mzero)
        w_fix = (r_neg_a ^ r_neg_b) ? ('0 - w_prod) : w_prod;
    end else begin
      if (r_div0) begin
        w_quot = '1;
        w_rem  = r_a_raw;
      end else if (r_ovf) begin
        w_quot = r_a_raw;
        w_rem  = '0;
      end else begin
        w_quot = (r_neg_a ^ r_neg_b) ? ('0 - r_lo) : r_lo;
        w_rem  = r_neg_a ? ('0 - r_hi) : r_hi;
      end
      w_fix = {w_rem, w_quot};
    end
  end

  assign w_sel = ((r_op == OP_MUL) | (r_op == OP_DIV) | (r_op == OP_DIVU))
               ? r_fix[XLEN-1:0] : r_fix[2*XLEN-1:XLEN];

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && !flush) begin
          w_accept     = 1'b1;
          w_next_state = w_early ? FIX : CALC;
        end
      end
      CALC: if (w_last) w_next_state = FIX;
      FIX:  if (r_fix_ph) w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush)
      w_next_state = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  // FIX spends two edges: sign correction, then output-word selection into Result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_mzero  <= 1'b0;
      r_a_raw  <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_fix_ph <= 1'b0;
      r_fix    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= w_op;
            r_neg_a  <= w_sgn_a;
            r_neg_b  <= w_sgn_b;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_mzero  <= w_mzero;
            r_a_raw  <= a;
            r_opnd   <= w_is_mul ? w_mag_a : w_mag_b;
            r_lo     <= w_is_mul ? w_mag_b : w_mag_a;
            r_hi     <= '0;
            r_cnt    <= '0;
            r_fix_ph <= 1'b0;
          end
        end
        CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_fix_ph <= 1'b1;
          if (!r_fix_ph)
            r_fix <= w_fix;
          else if (!flush)
            r_result <= w_sel;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Result    = r_result;
  assign Zero      = out_valid & (r_result == '0);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic vectors, latency, backpressure, reset and flush.
module tb_mdu_iter;

  localparam int XLEN     = 32;
  localparam int LAT_FULL = XLEN + 2;
`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_FAST = 2;
`else
  localparam int LAT_FAST = LAT_FULL;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] Result;
  logic            Zero;

  int n_checks = 0;
  int n_errors = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(o, x, y);
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, Result, exp);
    chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp == 32'd0)});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_xfer_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_xfer_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int lat;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_res", Result, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("mul",       3'b000, 32'd10,        32'd20,        32'd200,       LAT_FULL);
    run("mul_wrap",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         LAT_FULL);
    run("mulh",      3'b001, 32'hFFFF_FFF6, 32'd5,         32'hFFFF_FFFF, LAT_FULL);
    run("mulh_nn",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         LAT_FULL);
    run("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_FULL);
    run("mulhu",     3'b011, 32'hFFFF_FFFF, 32'd2,         32'd1,         LAT_FULL);
    run("mul_zero",  3'b000, 32'd0,         32'd5,         32'd0,         LAT_FAST);
    run("div",       3'b100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, LAT_FULL);
    run("rem",       3'b110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, LAT_FULL);
    run("divu",      3'b101, 32'd100,       32'd100,       32'd1,         LAT_FULL);
    run("remu",      3'b111, 32'd100,       32'd100,       32'd0,         LAT_FULL);
    run("divu_big",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_FULL);
    run("remu_big",  3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FULL);
    run("divu_z",    3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, LAT_FAST);
    run("div_z",     3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, LAT_FAST);
    run("rem_z",     3'b110, 32'd7,         32'd0,         32'd7,         LAT_FAST);
    run("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST);
    run("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_FAST);

    // Backpressure: result held, no accept while DONE
    issue(3'b000, 32'd6, 32'd7);
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'(LAT_FULL));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
      @(posedge clk);
      #1;
      chk("bp_hold_res", Result, 32'd42);
      chk("bp_hold_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_xfer_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_xfer_rdy", {31'd0, in_ready}, 32'd1);
    quiet_window("bp_no_ghost", LAT_FULL + 3);

    // Async reset at CALC iteration 10
    issue(3'b000, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", {31'd0, out_valid}, 32'd0);
    chk("arst_rdy", {31'd0, in_ready}, 32'd1);
    chk("arst_res", Result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_window("arst_discard", LAT_FULL + 3);
    run("after_rst", 3'b000, 32'd3, 32'd4, 32'd12, LAT_FULL);

    // Flush in DONE wins over out_ready
    issue(3'b101, 32'd50, 32'd5);
    wait_valid(lat);
    chk("fl_done_res", Result, 32'd10);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("fl_done_ov", {31'd0, out_valid}, 32'd0);
    chk("fl_done_rdy", {31'd0, in_ready}, 32'd1);

    // Flush with in_valid in IDLE: nothing accepted
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_idle_rdy", {31'd0, in_ready}, 32'd1);
    quiet_window("fl_idle_none", LAT_FULL + 3);

    // Flush mid-CALC discards the operation
    issue(3'b100, 32'd81, 32'd9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_calc_rdy", {31'd0, in_ready}, 32'd1);
    quiet_window("fl_calc_none", LAT_FULL + 3);
    run("after_fl", 3'b100, 32'd81, 32'd9, 32'd9, LAT_FULL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
